// File: rtl/reg_bus_master_pkg.sv
// Shared state encoding, opcode bit position and frame byte ordering for reg_bus_master.
// Optional feature macro (used by the top): REG_MASTER_NOSEL_CHECK_EN.
package reg_bus_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_LEN    = 3'd2,
      ST_WR     = 3'd3,
      ST_RD_STB = 3'd4,
      ST_RD_CAP = 3'd5,
      ST_RD_OUT = 3'd6
   } state_e;

   localparam int OPC_READ_BIT     = 0;

   localparam int FRAME_IDX_OPCODE = 0;
   localparam int FRAME_IDX_ADDR   = 1;
   localparam int FRAME_IDX_LEN    = 2;
   localparam int FRAME_IDX_DATA   = 3;

   function automatic logic is_rd_state(input state_e s);
      return (s == ST_RD_STB) || (s == ST_RD_CAP) || (s == ST_RD_OUT);
   endfunction

   function automatic logic is_hdr_state(input state_e s);
      return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_LEN);
   endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Byte-stream command parser driving the register bus; returns read data as a response stream.
// Define REG_MASTER_NOSEL_CHECK_EN to enable the sticky "strobe hit no block" flag.
module reg_bus_master
   import reg_bus_master_pkg::*;
#(
   parameter int pBYTECNT_SIZE = 7
) (
   input  logic                     cwusb_clk,
   input  logic                     reset_n,
   input  logic [7:0]               I_cmd_data,
   input  logic                     I_cmd_valid,
   output logic                     O_cmd_ready,
   output logic [7:0]               O_rsp_data,
   output logic                     O_rsp_valid,
   input  logic                     I_rsp_ready,
   output logic                     O_busy,
   output logic                     O_done,
   output logic                     O_nosel_err,
   input  logic                     I_nosel_clear,
   input  logic                     I_selected_any,
   output logic [7:0]               reg_address,
   output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   output logic                     reg_addrvalid,
   output logic                     reg_read,
   output logic                     reg_write,
   output logic [7:0]               write_data,
   input  logic [7:0]               read_data
);

   state_e                   state_q, state_d;
   logic [7:0]               rem_q, rem_d;
   logic [pBYTECNT_SIZE-1:0] bytecnt_q, bytecnt_d;
   logic [7:0]               addr_q, addr_d;
   logic [7:0]               wdata_q, wdata_d;
   logic [7:0]               rsp_data_q, rsp_data_d;
   logic                     is_read_q, is_read_d;
   logic                     wr_q, wr_d;
   logic                     rd_q, rd_d;
   logic                     done_q, done_d;
   logic                     cmd_ready_q, cmd_ready_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic                     busy_q, busy_d;
   logic                     addrvalid_q, addrvalid_d;
   logic                     cmd_acc_s, rsp_acc_s;

   assign cmd_acc_s = cmd_ready_q & I_cmd_valid;
   assign rsp_acc_s = rsp_valid_q & I_rsp_ready;

   // Next-state and registered-output decode; all outputs are computed from state_d so they leave flops.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      bytecnt_d  = bytecnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      is_read_d  = is_read_q;
      wr_d       = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_acc_s) begin
               is_read_d = I_cmd_data[OPC_READ_BIT];
               state_d   = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (cmd_acc_s) begin
               addr_d  = I_cmd_data;
               state_d = ST_LEN;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_LEN: begin
            if (cmd_acc_s) begin
               rem_d     = I_cmd_data;
               bytecnt_d = '0;
               if (I_cmd_data == 8'd0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (is_read_q) begin
                  state_d = ST_RD_STB;
               end else begin
                  state_d = ST_WR;
               end
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_WR: begin
            // bytecnt steps after each strobe; WR is held one extra cycle so the last strobe is not in IDLE
            if (wr_q) begin
               bytecnt_d = bytecnt_q + pBYTECNT_SIZE'(1);
            end else begin
               bytecnt_d = bytecnt_q;
            end
            if (cmd_acc_s) begin
               wr_d    = 1'b1;
               wdata_d = I_cmd_data;
               rem_d   = rem_q - 8'd1;
            end else if (rem_q == 8'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_WR;
            end
         end
         ST_RD_STB: state_d = ST_RD_CAP;
         ST_RD_CAP: begin
            rsp_data_d = read_data;
            state_d    = ST_RD_OUT;
         end
         ST_RD_OUT: begin
            if (rsp_acc_s) begin
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  bytecnt_d = bytecnt_q + pBYTECNT_SIZE'(1);
                  state_d   = ST_RD_STB;
               end
            end else begin
               state_d = ST_RD_OUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = is_hdr_state(state_d) || ((state_d == ST_WR) && (rem_d != 8'd0));
      rd_d        = (state_d == ST_RD_STB);
      rsp_valid_d = (state_d == ST_RD_OUT);
      busy_d      = (state_d != ST_IDLE);
      addrvalid_d = is_rd_state(state_d) || ((state_d == ST_WR) && (addrvalid_q || wr_d));
   end

   // State and output registers.
   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= 8'd0;
         bytecnt_q   <= '0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         rsp_data_q  <= 8'h00;
         is_read_q   <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         addrvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         bytecnt_q   <= bytecnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_data_q  <= rsp_data_d;
         is_read_q   <= is_read_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         addrvalid_q <= addrvalid_d;
      end
   end

   assign O_cmd_ready   = cmd_ready_q;
   assign O_rsp_data    = rsp_data_q;
   assign O_rsp_valid   = rsp_valid_q;
   assign O_busy        = busy_q;
   assign O_done        = done_q;
   assign reg_address   = addr_q;
   assign reg_bytecnt   = bytecnt_q;
   assign reg_addrvalid = addrvalid_q;
   assign reg_read      = rd_q;
   assign reg_write     = wr_q;
   assign write_data    = wdata_q;

`ifdef REG_MASTER_NOSEL_CHECK_EN
   logic nosel_q;

   // Sticky unselected-strobe flag; a new hit outranks a simultaneous clear.
   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         nosel_q <= 1'b0;
      end else if ((rd_q || wr_q) && !I_selected_any) begin
         nosel_q <= 1'b1;
      end else if (I_nosel_clear) begin
         nosel_q <= 1'b0;
      end else begin
         nosel_q <= nosel_q;
      end
   end

   assign O_nosel_err = nosel_q;
`else
   logic unused_nosel_s;
   assign unused_nosel_s = I_selected_any ^ I_nosel_clear;
   assign O_nosel_err    = 1'b0;
`endif

endmodule
